ledstrip_frame_sequencer: RTL

- Frame scheduler between the 4-character text/color buffers and the ws2812b strip driver.
- Periodically, or on request, walks every character glyph LED by LED and streams 24-bit GRB words to the driver over its valid/ready/latch handshake.
- Asserts latch on the final pixel of the frame.
- Replaces the ad-hoc update loop in the top level so the driver has a single owner with defined trigger, pending and blanking rules.

---
 rtl/ledstrip_frame_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ledstrip_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ledstrip_frame_sequencer
// Brief    : Walks every character glyph LED by LED and streams GRB words to
//            the ws2812b driver, latching on the final pixel of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module ledstrip_frame_sequencer #(
    parameter int NUM_CHARS      = 4,
    parameter int CHAR_LEDS      = 35,
    parameter int REFRESH_CYCLES = 131072
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 refresh_en,
    input  logic                 frame_req,
    input  logic                 blank,
    output logic [2:0]           char_sel,
    input  logic [CHAR_LEDS-1:0] glyph,
    input  logic [23:0]          color,
    output logic [23:0]          px_data,
    output logic                 px_valid,
    output logic                 px_latch,
    input  logic                 px_ready,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int                   c_tmr_w    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_tmr_w-1:0]   c_tmr_last = c_tmr_w'(REFRESH_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]   c_tmr_one  = c_tmr_w'(1);
    localparam logic [8:0]           c_total    = 9'(NUM_CHARS * CHAR_LEDS);
    localparam logic [8:0]           c_last_led = 9'(NUM_CHARS * CHAR_LEDS - 1);
    localparam logic [5:0]           c_bit_last = 6'(CHAR_LEDS - 1);
    localparam logic [CHAR_LEDS-1:0] c_glyph_one = CHAR_LEDS'(1);

    localparam logic [2:0] c_st_idle        = 3'd0;
    localparam logic [2:0] c_st_fetch       = 3'd1;
    localparam logic [2:0] c_st_load        = 3'd2;
    localparam logic [2:0] c_st_wait_ready  = 3'd3;
    localparam logic [2:0] c_st_wait_accept = 3'd4;

    logic [2:0]         r_state;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_pending;
    logic [8:0]         r_led_idx;
    logic [5:0]         r_bit_idx;
    logic [2:0]         r_char_sel;
    logic [23:0]        r_px_data;
    logic               r_px_valid;
    logic               r_px_latch;
    logic               r_busy;
    logic               r_frame_done;

    logic w_tick;
    logic w_trigger;
    logic w_glyph_bit;

    assign w_tick      = refresh_en && (r_timer == c_tmr_last);
    assign w_trigger   = w_tick || frame_req;
    assign w_glyph_bit = |(glyph & (c_glyph_one << r_bit_idx));

    assign char_sel   = r_char_sel;
    assign px_data    = r_px_data;
    assign px_valid   = r_px_valid;
    assign px_latch   = r_px_latch;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    // Free-running refresh timer; the tick is only honoured when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_timer == c_tmr_last) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_tmr_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_pending    <= 1'b0;
            r_led_idx    <= 9'd0;
            r_bit_idx    <= 6'd0;
            r_char_sel   <= 3'd0;
            r_px_data    <= 24'd0;
            r_px_valid   <= 1'b0;
            r_px_latch   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // Triggers during a frame (including its final cycle) collapse into one.
            if (w_trigger && r_busy) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_trigger || r_pending) begin
                        r_pending  <= 1'b0;
                        r_char_sel <= 3'd0;
                        r_led_idx  <= 9'd0;
                        r_bit_idx  <= 6'd0;
                        r_busy     <= 1'b1;
                        r_state    <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    r_state <= c_st_load;
                end
                c_st_load: begin
                    r_px_data  <= (blank || !w_glyph_bit) ? 24'd0 : color;
                    r_px_latch <= (r_led_idx == c_last_led);
                    r_state    <= c_st_wait_ready;
                end
                c_st_wait_ready: begin
                    if (px_ready) begin
                        r_px_valid <= 1'b1;
                        r_led_idx  <= r_led_idx + 9'd1;
                        if (r_bit_idx == c_bit_last) begin
                            r_bit_idx  <= 6'd0;
                            r_char_sel <= r_char_sel + 3'd1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 6'd1;
                        end
                        r_state <= c_st_wait_accept;
                    end
                end
                c_st_wait_accept: begin
                    // Driver drops ready once it has taken the word.
                    if (!px_ready) begin
                        r_px_valid <= 1'b0;
                        r_px_latch <= 1'b0;
                        if (r_led_idx == c_total) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= c_st_idle;
                        end else if (r_bit_idx == 6'd0) begin
                            r_state <= c_st_fetch;
                        end else begin
                            r_state <= c_st_load;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
